simon_axi_fifo_bridge: RTL and testbench

Parametrised AXI4 slave that bridges a CPU-side memory-mapped port onto the SIMON cipher's ingress and egress streaming FIFOs. Full-protocol successor to the earlier AXI-to-FIFO adapter:
- per-burst write responses with ID echo
- length-tracked read bursts with correct RLAST
- error signalling
- configurable data width and FIFO depth
- FIFO fill-level reporting

The write data stream feeds the cipher core; cipher output is returned on reads.

---
 rtl/simon_axi_pkg.sv | 22 ++
 rtl/simon_fwft_fifo.sv | 63 ++++++
 rtl/simon_axi_fifo_bridge.sv | 255 +++++++++++++++++++++++++
 tb/tb_simon_axi_fifo_bridge.sv | 386 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/simon_axi_pkg.sv
// Shared constants for the SIMON AXI-to-FIFO bridge: response codes, FSM state
// encodings and the burst-size helper.
package simon_axi_pkg;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  // Write FSM states
  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_DATA = 2'd1;
  localparam logic [1:0] W_RESP = 2'd2;

  // Read FSM states
  localparam logic R_IDLE = 1'b0;
  localparam logic R_DATA = 1'b1;

  // AXI size encoding for a beat of the given byte count (bytes is a power of 2).
  function automatic logic [2:0] log2_bytes(input int unsigned bytes);
    return 3'($clog2(bytes));
  endfunction

endpackage

// File: rtl/simon_fwft_fifo.sv
// First-word fall-through FIFO with level output; head word is visible on dout
// whenever empty is low.
module simon_fwft_fifo #(
  parameter int unsigned WIDTH = 128,
  parameter int unsigned DEPTH = 4096
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned PTR_W = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             push_en;
  logic             pop_en;

  // Requests against a full/empty FIFO are ignored; no same-cycle bypass.
  assign push_en = push & ~full;
  assign pop_en  = pop & ~empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_en) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop_en) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push_en) begin
      mem[wr_ptr_q[AW-1:0]] <= din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  assign dout  = mem[rd_ptr_q[AW-1:0]];
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign level = wr_ptr_q - rd_ptr_q;

endmodule

// File: rtl/simon_axi_fifo_bridge.sv
// AXI4 slave bridging write bursts into the SIMON ingress FIFO and serving read
// bursts from the egress FIFO, with independent write and read FSMs.
module simon_axi_fifo_bridge
  import simon_axi_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 128,
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned LEN_WIDTH  = 8,
  parameter int unsigned FIFO_DEPTH = 4096
) (
  input  logic                          clk,
  input  logic                          rst,
  // Write address
  input  logic [ID_WIDTH-1:0]           s_awid,
  input  logic [31:0]                   s_awaddr,
  input  logic [LEN_WIDTH-1:0]          s_awlen,
  input  logic [2:0]                    s_awsize,
  input  logic [1:0]                    s_awburst,
  input  logic                          s_awvalid,
  output logic                          s_awready,
  // Write data
  input  logic [DATA_WIDTH-1:0]         s_wdata,
  input  logic [DATA_WIDTH/8-1:0]       s_wstrb,
  input  logic                          s_wlast,
  input  logic                          s_wvalid,
  output logic                          s_wready,
  // Write response
  output logic [ID_WIDTH-1:0]           s_bid,
  output logic [1:0]                    s_bresp,
  output logic                          s_bvalid,
  input  logic                          s_bready,
  // Read address
  input  logic [ID_WIDTH-1:0]           s_arid,
  input  logic [31:0]                   s_araddr,
  input  logic [LEN_WIDTH-1:0]          s_arlen,
  input  logic [2:0]                    s_arsize,
  input  logic [1:0]                    s_arburst,
  input  logic                          s_arvalid,
  output logic                          s_arready,
  // Read data
  output logic [ID_WIDTH-1:0]           s_rid,
  output logic [DATA_WIDTH-1:0]         s_rdata,
  output logic [1:0]                    s_rresp,
  output logic                          s_rlast,
  output logic                          s_rvalid,
  input  logic                          s_rready,
  // Cipher streams
  output logic [DATA_WIDTH-1:0]         ingress_dout,
  output logic                          ingress_vld,
  input  logic                          ingress_rdy,
  input  logic [DATA_WIDTH-1:0]         egress_din,
  input  logic                          egress_vld,
  output logic                          egress_rdy,
  output logic [$clog2(FIFO_DEPTH):0]   ingress_level,
  output logic [$clog2(FIFO_DEPTH):0]   egress_level
);

  localparam int unsigned STRB_W    = DATA_WIDTH / 8;
  localparam logic [2:0]  SIZE_FULL = log2_bytes(STRB_W);

  logic ing_full, ing_empty;
  logic eg_full, eg_empty;
  logic [DATA_WIDTH-1:0] eg_dout;

  // Address and burst type carry no meaning for a streaming target.
  logic unused_addr;
  assign unused_addr = ^{s_awaddr, s_awburst, s_araddr, s_arburst};

  // ---------------------------------------------------------------------------
  // Write FSM
  // ---------------------------------------------------------------------------
  logic [1:0]           w_state_q, w_state_d;
  logic [ID_WIDTH-1:0]  awid_q, awid_d;
  logic [LEN_WIDTH-1:0] awlen_q, awlen_d;
  logic [LEN_WIDTH-1:0] w_beat_q, w_beat_d;
  logic                 w_sizeok_q, w_sizeok_d;
  logic                 w_err_q, w_err_d;
  logic                 w_fire;
  logic                 w_last_beat;
  logic                 w_beat_bad;

  assign w_fire      = s_wvalid & s_wready;
  assign w_last_beat = (w_beat_q == awlen_q);
  assign w_beat_bad  = ~(&s_wstrb) | ~w_sizeok_q | (s_wlast != w_last_beat);

  always_comb begin
    w_state_d  = w_state_q;
    awid_d     = awid_q;
    awlen_d    = awlen_q;
    w_beat_d   = w_beat_q;
    w_sizeok_d = w_sizeok_q;
    w_err_d    = w_err_q;
    case (w_state_q)
      W_IDLE: begin
        if (s_awvalid) begin
          awid_d     = s_awid;
          awlen_d    = s_awlen;
          w_sizeok_d = (s_awsize == SIZE_FULL);
          w_beat_d   = '0;
          w_err_d    = 1'b0;
          w_state_d  = W_DATA;
        end
      end
      W_DATA: begin
        if (w_fire) begin
          if (w_beat_bad) begin
            w_err_d = 1'b1;
          end
          // Burst length is counted in beats; wlast only feeds the error check.
          if (w_last_beat) begin
            w_state_d = W_RESP;
          end else begin
            w_beat_d = w_beat_q + LEN_WIDTH'(1);
          end
        end
      end
      W_RESP: begin
        if (s_bready) begin
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state_q  <= W_IDLE;
      awid_q     <= '0;
      awlen_q    <= '0;
      w_beat_q   <= '0;
      w_sizeok_q <= 1'b0;
      w_err_q    <= 1'b0;
    end else begin
      w_state_q  <= w_state_d;
      awid_q     <= awid_d;
      awlen_q    <= awlen_d;
      w_beat_q   <= w_beat_d;
      w_sizeok_q <= w_sizeok_d;
      w_err_q    <= w_err_d;
    end
  end

  assign s_awready = (w_state_q == W_IDLE);
  assign s_wready  = (w_state_q == W_DATA) & ~ing_full;
  assign s_bvalid  = (w_state_q == W_RESP);
  assign s_bid     = awid_q;
  assign s_bresp   = w_err_q ? AXI_RESP_SLVERR : AXI_RESP_OKAY;

  // ---------------------------------------------------------------------------
  // Read FSM
  // ---------------------------------------------------------------------------
  logic                 r_state_q, r_state_d;
  logic [ID_WIDTH-1:0]  arid_q, arid_d;
  logic [LEN_WIDTH-1:0] arlen_q, arlen_d;
  logic [LEN_WIDTH-1:0] r_beat_q, r_beat_d;
  logic                 r_sizeok_q, r_sizeok_d;
  logic                 r_active;
  logic                 r_last_beat;
  logic                 r_fire;

  assign r_active    = (r_state_q == R_DATA);
  assign r_last_beat = (r_beat_q == arlen_q);
  assign r_fire      = s_rvalid & s_rready;

  always_comb begin
    r_state_d  = r_state_q;
    arid_d     = arid_q;
    arlen_d    = arlen_q;
    r_beat_d   = r_beat_q;
    r_sizeok_d = r_sizeok_q;
    case (r_state_q)
      R_IDLE: begin
        if (s_arvalid) begin
          arid_d     = s_arid;
          arlen_d    = s_arlen;
          r_sizeok_d = (s_arsize == SIZE_FULL);
          r_beat_d   = '0;
          r_state_d  = R_DATA;
        end
      end
      R_DATA: begin
        if (r_fire) begin
          if (r_last_beat) begin
            r_state_d = R_IDLE;
          end else begin
            r_beat_d = r_beat_q + LEN_WIDTH'(1);
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state_q  <= R_IDLE;
      arid_q     <= '0;
      arlen_q    <= '0;
      r_beat_q   <= '0;
      r_sizeok_q <= 1'b0;
    end else begin
      r_state_q  <= r_state_d;
      arid_q     <= arid_d;
      arlen_q    <= arlen_d;
      r_beat_q   <= r_beat_d;
      r_sizeok_q <= r_sizeok_d;
    end
  end

  assign s_arready = (r_state_q == R_IDLE);
  assign s_rvalid  = r_active & ~eg_empty;
  // Head word is masked while invalid so rdata is defined out of reset.
  assign s_rdata   = s_rvalid ? eg_dout : '0;
  assign s_rlast   = r_active & r_last_beat;
  assign s_rresp   = (r_active && !r_sizeok_q) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
  assign s_rid     = arid_q;

  // ---------------------------------------------------------------------------
  // FIFOs
  // ---------------------------------------------------------------------------
  simon_fwft_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_ingress_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_fire),
    .din   (s_wdata),
    .pop   (ingress_rdy),
    .dout  (ingress_dout),
    .full  (ing_full),
    .empty (ing_empty),
    .level (ingress_level)
  );

  simon_fwft_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_egress_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (egress_vld),
    .din   (egress_din),
    .pop   (r_fire),
    .dout  (eg_dout),
    .full  (eg_full),
    .empty (eg_empty),
    .level (egress_level)
  );

  assign ingress_vld = ~ing_empty;
  assign egress_rdy  = ~eg_full;

endmodule

// File: tb/tb_simon_axi_fifo_bridge.sv
// Directed self-checking bench for simon_axi_fifo_bridge with an 8-deep FIFO.
module tb_simon_axi_fifo_bridge;

  localparam int unsigned DW    = 128;
  localparam int unsigned IW    = 4;
  localparam int unsigned LW    = 8;
  localparam int unsigned DEPTH = 8;

  logic            clk;
  logic            rst;
  logic [IW-1:0]   s_awid;
  logic [31:0]     s_awaddr;
  logic [LW-1:0]   s_awlen;
  logic [2:0]      s_awsize;
  logic [1:0]      s_awburst;
  logic            s_awvalid;
  logic            s_awready;
  logic [DW-1:0]   s_wdata;
  logic [DW/8-1:0] s_wstrb;
  logic            s_wlast;
  logic            s_wvalid;
  logic            s_wready;
  logic [IW-1:0]   s_bid;
  logic [1:0]      s_bresp;
  logic            s_bvalid;
  logic            s_bready;
  logic [IW-1:0]   s_arid;
  logic [31:0]     s_araddr;
  logic [LW-1:0]   s_arlen;
  logic [2:0]      s_arsize;
  logic [1:0]      s_arburst;
  logic            s_arvalid;
  logic            s_arready;
  logic [IW-1:0]   s_rid;
  logic [DW-1:0]   s_rdata;
  logic [1:0]      s_rresp;
  logic            s_rlast;
  logic            s_rvalid;
  logic            s_rready;
  logic [DW-1:0]   ingress_dout;
  logic            ingress_vld;
  logic            ingress_rdy;
  logic [DW-1:0]   egress_din;
  logic            egress_vld;
  logic            egress_rdy;
  logic [3:0]      ingress_level;
  logic [3:0]      egress_level;

  int tests = 0;
  int fails = 0;

  simon_axi_fifo_bridge #(
    .DATA_WIDTH (DW),
    .ID_WIDTH   (IW),
    .LEN_WIDTH  (LW),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .s_awid        (s_awid),
    .s_awaddr      (s_awaddr),
    .s_awlen       (s_awlen),
    .s_awsize      (s_awsize),
    .s_awburst     (s_awburst),
    .s_awvalid     (s_awvalid),
    .s_awready     (s_awready),
    .s_wdata       (s_wdata),
    .s_wstrb       (s_wstrb),
    .s_wlast       (s_wlast),
    .s_wvalid      (s_wvalid),
    .s_wready      (s_wready),
    .s_bid         (s_bid),
    .s_bresp       (s_bresp),
    .s_bvalid      (s_bvalid),
    .s_bready      (s_bready),
    .s_arid        (s_arid),
    .s_araddr      (s_araddr),
    .s_arlen       (s_arlen),
    .s_arsize      (s_arsize),
    .s_arburst     (s_arburst),
    .s_arvalid     (s_arvalid),
    .s_arready     (s_arready),
    .s_rid         (s_rid),
    .s_rdata       (s_rdata),
    .s_rresp       (s_rresp),
    .s_rlast       (s_rlast),
    .s_rvalid      (s_rvalid),
    .s_rready      (s_rready),
    .ingress_dout  (ingress_dout),
    .ingress_vld   (ingress_vld),
    .ingress_rdy   (ingress_rdy),
    .egress_din    (egress_din),
    .egress_vld    (egress_vld),
    .egress_rdy    (egress_rdy),
    .ingress_level (ingress_level),
    .egress_level  (egress_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "bench did not finish");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] pat(input int unsigned t);
    logic [31:0] v;
    v = t;
    return {v ^ 32'hC0DE_0000, ~v, v ^ 32'h5A5A_5A5A, v};
  endfunction

  task automatic aw(input logic [3:0] id, input logic [7:0] len, input logic [2:0] size);
    s_awid    = id;
    s_awlen   = len;
    s_awsize  = size;
    s_awvalid = 1'b1;
    chk("awready", s_awready, 1'b1);
    step();
    s_awvalid = 1'b0;
  endtask

  task automatic ar(input logic [3:0] id, input logic [7:0] len, input logic [2:0] size);
    s_arid    = id;
    s_arlen   = len;
    s_arsize  = size;
    s_arvalid = 1'b1;
    chk("arready", s_arready, 1'b1);
    step();
    s_arvalid = 1'b0;
  endtask

  task automatic w_beat(input logic [127:0] data, input logic [15:0] strb, input logic last);
    logic ok;
    ok       = 1'b0;
    s_wdata  = data;
    s_wstrb  = strb;
    s_wlast  = last;
    s_wvalid = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      if (s_wready) ok = 1'b1;
      step();
    end
    s_wvalid = 1'b0;
    chk("w_handshake", ok, 1'b1);
  endtask

  task automatic b_resp(input logic [3:0] id, input logic [1:0] resp);
    chk("bvalid", s_bvalid, 1'b1);
    chk("bid", s_bid, id);
    chk("bresp", s_bresp, resp);
    s_bready = 1'b1;
    step();
    s_bready = 1'b0;
    chk("bvalid_after_b", s_bvalid, 1'b0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    ingress_rdy = 1'b1;
    while (ingress_vld && n < 50) begin
      step();
      n++;
    end
    ingress_rdy = 1'b0;
    chk("drain_level", ingress_level, 4'd0);
  endtask

  initial begin
    int got;
    s_awid = '0; s_awaddr = 32'h1000; s_awlen = '0; s_awsize = 3'd4; s_awburst = 2'b01;
    s_awvalid = 1'b0; s_wdata = '0; s_wstrb = '0; s_wlast = 1'b0; s_wvalid = 1'b0;
    s_bready = 1'b0; s_arid = '0; s_araddr = 32'h2000; s_arlen = '0; s_arsize = 3'd4;
    s_arburst = 2'b01; s_arvalid = 1'b0; s_rready = 1'b0; ingress_rdy = 1'b0;
    egress_din = '0; egress_vld = 1'b0;
    rst = 1'b1;
    repeat (3) step();

    // Reset values
    chk("rst_awready", s_awready, 1'b1);
    chk("rst_arready", s_arready, 1'b1);
    chk("rst_wready", s_wready, 1'b0);
    chk("rst_bvalid", s_bvalid, 1'b0);
    chk("rst_bresp", s_bresp, 2'b00);
    chk("rst_bid", s_bid, 4'd0);
    chk("rst_rvalid", s_rvalid, 1'b0);
    chk("rst_rlast", s_rlast, 1'b0);
    chk("rst_rresp", s_rresp, 2'b00);
    chk("rst_rid", s_rid, 4'd0);
    chk("rst_rdata", s_rdata, 128'd0);
    chk("rst_ingress_vld", ingress_vld, 1'b0);
    chk("rst_egress_rdy", egress_rdy, 1'b1);
    chk("rst_ingress_level", ingress_level, 4'd0);
    chk("rst_egress_level", egress_level, 4'd0);
    rst = 1'b0;
    step();

    // Single write; pop attempted during the push into an empty FIFO has no effect
    ingress_rdy = 1'b1;
    aw(4'd3, 8'd0, 3'd4);
    chk("wready_after_aw", s_wready, 1'b1);
    w_beat(128'h1, 16'hFFFF, 1'b1);
    chk("single_ingress_vld", ingress_vld, 1'b1);
    chk("single_ingress_dout", ingress_dout, 128'h1);
    chk("single_ingress_level", ingress_level, 4'd1);
    step();
    ingress_rdy = 1'b0;
    chk("single_popped_level", ingress_level, 4'd0);
    chk("single_popped_vld", ingress_vld, 1'b0);
    b_resp(4'd3, 2'b00);

    // 4-beat write held in the FIFO, then drained in order
    aw(4'd1, 8'd3, 3'd4);
    for (int i = 0; i < 4; i++) begin
      w_beat(pat(16 + i), 16'hFFFF, i == 3);
      if (i < 3) chk("bvalid_midburst", s_bvalid, 1'b0);
    end
    chk("burst4_level", ingress_level, 4'd4);
    b_resp(4'd1, 2'b00);
    ingress_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("burst4_vld", ingress_vld, 1'b1);
      chk("burst4_dout", ingress_dout, pat(16 + i));
      step();
    end
    ingress_rdy = 1'b0;
    chk("burst4_drained", ingress_level, 4'd0);

    // Partial strobe on beat 2
    aw(4'd2, 8'd1, 3'd4);
    w_beat(pat(32), 16'hFFFF, 1'b0);
    w_beat(pat(33), 16'h00FF, 1'b1);
    chk("strb_err_level", ingress_level, 4'd2);
    b_resp(4'd2, 2'b10);
    drain();

    // Early wlast: burst still takes both beats
    aw(4'd4, 8'd1, 3'd4);
    w_beat(pat(40), 16'hFFFF, 1'b1);
    chk("early_last_no_b", s_bvalid, 1'b0);
    chk("early_last_wready", s_wready, 1'b1);
    w_beat(pat(41), 16'hFFFF, 1'b1);
    chk("early_last_level", ingress_level, 4'd2);
    b_resp(4'd4, 2'b10);
    drain();

    // Narrow size
    aw(4'd6, 8'd0, 3'd3);
    w_beat(pat(48), 16'hFFFF, 1'b1);
    b_resp(4'd6, 2'b10);
    drain();

    // Fill egress to full, then 8-beat read with rready toggling
    egress_vld = 1'b1;
    for (int i = 0; i < 8; i++) begin
      egress_din = pat(64 + i);
      chk("egress_rdy_fill", egress_rdy, 1'b1);
      step();
    end
    egress_vld = 1'b0;
    chk("egress_full_level", egress_level, 4'd8);
    chk("egress_full_rdy", egress_rdy, 1'b0);
    ar(4'd5, 8'd7, 3'd4);
    chk("arready_busy", s_arready, 1'b0);
    got = 0;
    for (int c = 0; c < 64 && got < 8; c++) begin
      s_rready = c[0];
      chk("rvalid_hold", s_rvalid, 1'b1);
      if (s_rready) begin
        chk("rdata", s_rdata, pat(64 + got));
        chk("rid", s_rid, 4'd5);
        chk("rlast", s_rlast, got == 7);
        chk("rresp", s_rresp, 2'b00);
        got++;
      end
      step();
    end
    s_rready = 1'b0;
    chk("read_beats", got, 8);
    chk("read_egress_level", egress_level, 4'd0);
    chk("read_done_arready", s_arready, 1'b1);
    chk("read_done_rvalid", s_rvalid, 1'b0);

    // Ingress backpressure at full
    aw(4'd7, 8'd7, 3'd4);
    for (int i = 0; i < 8; i++) w_beat(pat(80 + i), 16'hFFFF, i == 7);
    chk("ingress_full_level", ingress_level, 4'd8);
    b_resp(4'd7, 2'b00);
    aw(4'd8, 8'd0, 3'd4);
    chk("full_wready", s_wready, 1'b0);
    s_wdata  = pat(96);
    s_wstrb  = 16'hFFFF;
    s_wlast  = 1'b1;
    s_wvalid = 1'b1;
    step();
    chk("full_wready_hold", s_wready, 1'b0);
    chk("full_no_push", ingress_level, 4'd8);
    ingress_rdy = 1'b1;
    step();
    ingress_rdy = 1'b0;
    chk("after_pop_level", ingress_level, 4'd7);
    chk("after_pop_wready", s_wready, 1'b1);
    w_beat(pat(96), 16'hFFFF, 1'b1);
    chk("refill_level", ingress_level, 4'd8);
    b_resp(4'd8, 2'b00);
    ingress_rdy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("bp_dout", ingress_dout, (i < 7) ? pat(81 + i) : pat(96));
      step();
    end
    ingress_rdy = 1'b0;
    chk("bp_drained", ingress_level, 4'd0);

    // Read against an empty egress FIFO, narrow size
    ar(4'd9, 8'd0, 3'd3);
    s_rready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("empty_rvalid", s_rvalid, 1'b0);
      step();
    end
    egress_vld = 1'b1;
    egress_din = pat(112);
    step();
    egress_vld = 1'b0;
    chk("late_egress_level", egress_level, 4'd1);
    chk("late_rvalid", s_rvalid, 1'b1);
    chk("late_rdata", s_rdata, pat(112));
    chk("late_rlast", s_rlast, 1'b1);
    chk("late_rresp", s_rresp, 2'b10);
    chk("late_rid", s_rid, 4'd9);
    step();
    s_rready = 1'b0;
    chk("late_done_rvalid", s_rvalid, 1'b0);
    chk("late_done_arready", s_arready, 1'b1);
    chk("late_done_level", egress_level, 4'd0);

    // Reset in the middle of a 4-beat write
    aw(4'd11, 8'd3, 3'd4);
    w_beat(pat(120), 16'hFFFF, 1'b0);
    w_beat(pat(121), 16'hFFFF, 1'b0);
    chk("pre_rst_level", ingress_level, 4'd2);
    rst = 1'b1;
    #2;
    chk("midrst_level", ingress_level, 4'd0);
    chk("midrst_awready", s_awready, 1'b1);
    chk("midrst_wready", s_wready, 1'b0);
    chk("midrst_bvalid", s_bvalid, 1'b0);
    step();
    rst = 1'b0;
    step();
    chk("postrst_awready", s_awready, 1'b1);
    chk("postrst_bvalid", s_bvalid, 1'b0);
    chk("postrst_level", ingress_level, 4'd0);
    aw(4'd12, 8'd1, 3'd4);
    w_beat(pat(124), 16'hFFFF, 1'b0);
    w_beat(pat(125), 16'hFFFF, 1'b1);
    b_resp(4'd12, 2'b00);
    ingress_rdy = 1'b1;
    chk("postrst_dout0", ingress_dout, pat(124));
    step();
    chk("postrst_dout1", ingress_dout, pat(125));
    step();
    ingress_rdy = 1'b0;
    chk("postrst_drained", ingress_level, 4'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
